// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: title -> map select -> map draw -> play -> game over -> title.
// Handshakes with the VGA draw datapath and paces gameplay with a per-frame tick.
module game_flow_ctrl #(
    parameter int FRAME_DIV      = 833333,
    parameter int GG_HOLD_FRAMES = 180
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       button1,
    input  logic       button2,
    input  logic       game_over,
    input  logic       draw_done,
    output logic [5:0] current_state,
    output logic [1:0] map_select,
    output logic       draw_start,
    output logic       play_en,
    output logic       frame_tick
);

    localparam logic [5:0] S_IDLE       = 6'd0;
    localparam logic [5:0] S_DRAW_TITLE = 6'd1;
    localparam logic [5:0] S_WAIT_SEL   = 6'd11;
    localparam logic [5:0] S_DRAW_MAP   = 6'd12;
    localparam logic [5:0] S_PLAY       = 6'd13;
    localparam logic [5:0] S_DRAW_GG    = 6'd14;
    localparam logic [5:0] S_GG_HOLD    = 6'd15;

    localparam logic [1:0] MAP1  = 2'b00;
    localparam logic [1:0] MAP2  = 2'b01;
    localparam logic [1:0] START = 2'b10;
    localparam logic [1:0] GG    = 2'b11;

    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int HW = $clog2(GG_HOLD_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(GG_HOLD_FRAMES - 1);

    logic [5:0]    state, next_state;
    logic [1:0]    map_next;
    logic          draw_next;
    logic [1:0]    btn_p0, btn_p1, btn_p2;
    logic [1:0]    btn_edge;
    logic [FW-1:0] frame_cnt;
    logic [HW-1:0] hold_cnt;
    logic          cnt_active, next_active, done_ok;

    // Buttons: two synchronizer stages, then a third stage for rising-edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_p0 <= '0;
            btn_p1 <= '0;
            btn_p2 <= '0;
        end else begin
            btn_p0 <= {button2, button1};
            btn_p1 <= btn_p0;
            btn_p2 <= btn_p1;
        end
    end

    assign btn_edge    = btn_p1 & ~btn_p2;
    assign cnt_active  = (state == S_PLAY) || (state == S_GG_HOLD);
    assign next_active = (next_state == S_PLAY) || (next_state == S_GG_HOLD);
    // draw_start is high only on a draw state's entry cycle, so this masks coincident done
    assign done_ok     = draw_done && !draw_start;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        map_next   = map_select;
        unique case (state)
            S_IDLE:       next_state = S_DRAW_TITLE;
            S_DRAW_TITLE: if (done_ok) next_state = S_WAIT_SEL;
            S_WAIT_SEL: begin
                if (btn_edge[0]) begin
                    next_state = S_DRAW_MAP;
                    map_next   = MAP1;
                end else if (btn_edge[1]) begin
                    next_state = S_DRAW_MAP;
                    map_next   = MAP2;
                end
            end
            S_DRAW_MAP:   if (done_ok) next_state = S_PLAY;
            S_PLAY:       if (game_over) next_state = S_DRAW_GG;
            S_DRAW_GG:    if (done_ok) next_state = S_GG_HOLD;
            S_GG_HOLD:    if (frame_tick && (hold_cnt == HOLD_LAST)) next_state = S_DRAW_TITLE;
            default:      next_state = S_IDLE;
        endcase
        if (next_state == S_DRAW_TITLE) map_next = START;
        if (next_state == S_DRAW_GG)    map_next = GG;
        draw_next = (next_state != state) &&
                    ((next_state == S_DRAW_TITLE) || (next_state == S_DRAW_MAP) ||
                     (next_state == S_DRAW_GG));
    end

    always_comb begin
        current_state = state;
        play_en       = (state == S_PLAY);
        frame_tick    = cnt_active && (frame_cnt == FRAME_LAST);
    end

    // Frame counter only runs while staying in a paced state, so entry always starts at zero
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            map_select <= START;
            draw_start <= 1'b0;
            frame_cnt  <= '0;
            hold_cnt   <= '0;
        end else begin
            map_select <= map_next;
            draw_start <= draw_next;
            if (cnt_active && next_active)
                frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
            else
                frame_cnt <= '0;
            if (state != S_GG_HOLD)
                hold_cnt <= '0;
            else if (frame_tick)
                hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with FRAME_DIV = 4, GG_HOLD_FRAMES = 3.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       resetn, button1, button2, game_over, draw_done;
    logic [5:0] current_state;
    logic [1:0] map_select;
    logic       draw_start, play_en, frame_tick;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n;

    game_flow_ctrl #(.FRAME_DIV(4), .GG_HOLD_FRAMES(3)) dut (
        .clk(clk), .resetn(resetn), .button1(button1), .button2(button2),
        .game_over(game_over), .draw_done(draw_done), .current_state(current_state),
        .map_select(map_select), .draw_start(draw_start), .play_en(play_en),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_draw_done();
        draw_done = 1'b1;
        step();
        draw_done = 1'b0;
    endtask

    task automatic pulse_game_over();
        game_over = 1'b1;
        step();
        game_over = 1'b0;
    endtask

    task automatic press_btn(input logic b1, input logic b2);
        button1 = b1;
        button2 = b2;
        repeat (3) step();
        button1 = 1'b0;
        button2 = 1'b0;
    endtask

    // Steps until the target state appears; cycles = -1 when the bound expires
    task automatic wait_state(input logic [5:0] target, input int max, output int cycles);
        cycles = 0;
        while (current_state !== target && cycles <= max) begin
            step();
            cycles++;
        end
        if (current_state !== target) cycles = -1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; button1 = 0; button2 = 0; game_over = 0; draw_done = 0;
        step(); step();
        n_tests++; if (current_state !== 6'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", current_state); end
        n_tests++; if (map_select !== 2'b10) begin n_fail++; $display("FAIL reset_map got %b want 10", map_select); end
        n_tests++; if ({draw_start, play_en, frame_tick} !== 3'b000) begin n_fail++; $display("FAIL reset_outs got %b want 000", {draw_start, play_en, frame_tick}); end
        resetn = 1'b1;
        step();
        n_tests++; if (current_state !== 6'd1 || draw_start !== 1'b1 || map_select !== 2'b10) begin n_fail++; $display("FAIL title_entry got st=%0d ds=%b map=%b want 1 1 10", current_state, draw_start, map_select); end
        step();
        n_tests++; if (draw_start !== 1'b0 || current_state !== 6'd1) begin n_fail++; $display("FAIL title_ds_pulse got ds=%b st=%0d want 0 1", draw_start, current_state); end
        repeat (3) step();
        pulse_draw_done();
        n_tests++; if (current_state !== 6'd11 || map_select !== 2'b10) begin n_fail++; $display("FAIL wait_sel got st=%0d map=%b want 11 10", current_state, map_select); end
    endtask

    task automatic test_map_btn2();
        button2 = 1'b1;
        step(); step();
        n_tests++; if (current_state !== 6'd11) begin n_fail++; $display("FAIL btn_latency got st=%0d want 11", current_state); end
        step();
        button2 = 1'b0;
        n_tests++; if (current_state !== 6'd12 || map_select !== 2'b01 || draw_start !== 1'b1) begin n_fail++; $display("FAIL map2_sel got st=%0d map=%b ds=%b want 12 01 1", current_state, map_select, draw_start); end
        pulse_draw_done();
        n_tests++; if (current_state !== 6'd12) begin n_fail++; $display("FAIL done_with_start got st=%0d want 12", current_state); end
        pulse_draw_done();
        n_tests++; if (current_state !== 6'd13 || play_en !== 1'b1) begin n_fail++; $display("FAIL enter_play got st=%0d en=%b want 13 1", current_state, play_en); end
    endtask

    task automatic test_play_tick();
        for (int i = 1; i <= 8; i++) begin
            n_tests++; if (frame_tick !== ((i % 4) == 0)) begin n_fail++; $display("FAIL tick_cycle%0d got %b want %b", i, frame_tick, (i % 4) == 0); end
            step();
        end
        button1 = 1'b1; button2 = 1'b1;
        repeat (5) step();
        button1 = 1'b0; button2 = 1'b0;
        n_tests++; if (current_state !== 6'd13 || map_select !== 2'b01) begin n_fail++; $display("FAIL play_btn_ignored got st=%0d map=%b want 13 01", current_state, map_select); end
    endtask

    task automatic test_game_over();
        pulse_game_over();
        n_tests++; if (current_state !== 6'd14 || map_select !== 2'b11 || draw_start !== 1'b1 || play_en !== 1'b0) begin n_fail++; $display("FAIL gg_entry got st=%0d map=%b ds=%b en=%b want 14 11 1 0", current_state, map_select, draw_start, play_en); end
        step();
        pulse_draw_done();
        n_tests++; if (current_state !== 6'd15) begin n_fail++; $display("FAIL gg_hold got st=%0d want 15", current_state); end
        wait_state(6'd1, 20, n);
        n_tests++; if (n !== 12) begin n_fail++; $display("FAIL gg_hold_len got %0d cycles want 12", n); end
        n_tests++; if (map_select !== 2'b10 || draw_start !== 1'b1) begin n_fail++; $display("FAIL back_title got map=%b ds=%b want 10 1", map_select, draw_start); end
        step();
        pulse_draw_done();
    endtask

    task automatic test_spurious_game_over();
        pulse_game_over();
        repeat (3) step();
        n_tests++; if (current_state !== 6'd11) begin n_fail++; $display("FAIL game_over_in_sel got st=%0d want 11", current_state); end
    endtask

    task automatic test_both_buttons();
        press_btn(1'b1, 1'b1);
        n_tests++; if (current_state !== 6'd12 || map_select !== 2'b00) begin n_fail++; $display("FAIL both_btn got st=%0d map=%b want 12 00", current_state, map_select); end
    endtask

    task automatic test_async_reset_draw();
        #2 resetn = 1'b0;
        #1;
        n_tests++; if (current_state !== 6'd0 || map_select !== 2'b10 || draw_start !== 1'b0) begin n_fail++; $display("FAIL async_rst_draw got st=%0d map=%b ds=%b want 0 10 0", current_state, map_select, draw_start); end
        step();
        resetn = 1'b1;
        step();
        n_tests++; if (current_state !== 6'd1 || draw_start !== 1'b1) begin n_fail++; $display("FAIL restart got st=%0d ds=%b want 1 1", current_state, draw_start); end
        step();
        pulse_draw_done();
    endtask

    task automatic test_held_button();
        button1 = 1'b1;
        wait_state(6'd12, 5, n);
        n_tests++; if (n !== 3 || map_select !== 2'b00) begin n_fail++; $display("FAIL held_sel got %0d cycles map=%b want 3 00", n, map_select); end
        step();
        pulse_draw_done();
        pulse_game_over();
        step();
        pulse_draw_done();
        wait_state(6'd1, 20, n);
        step();
        pulse_draw_done();
        repeat (75) step();
        n_tests++; if (current_state !== 6'd11) begin n_fail++; $display("FAIL held_single got st=%0d want 11", current_state); end
        button1 = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_async_reset_hold();
        press_btn(1'b0, 1'b1);
        step();
        pulse_draw_done();
        pulse_game_over();
        step();
        pulse_draw_done();
        repeat (3) step();
        n_tests++; if (current_state !== 6'd15 || frame_tick !== 1'b1) begin n_fail++; $display("FAIL hold_tick got st=%0d tick=%b want 15 1", current_state, frame_tick); end
        #2 resetn = 1'b0;
        #1;
        n_tests++; if (current_state !== 6'd0 || frame_tick !== 1'b0 || map_select !== 2'b10 || play_en !== 1'b0) begin n_fail++; $display("FAIL async_rst_hold got st=%0d tick=%b map=%b en=%b want 0 0 10 0", current_state, frame_tick, map_select, play_en); end
        step();
        resetn = 1'b1;
        #1;
        n_tests++; if (current_state !== 6'd0) begin n_fail++; $display("FAIL rst_release got st=%0d want 0", current_state); end
        step();
        n_tests++; if (current_state !== 6'd1) begin n_fail++; $display("FAIL rst_restart got st=%0d want 1", current_state); end
    endtask

    initial begin
        test_reset();
        test_map_btn2();
        test_play_tick();
        test_game_over();
        test_spurious_game_over();
        test_both_buttons();
        test_async_reset_draw();
        test_held_button();
        test_async_reset_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer. Steps the design through title screen, map selection, map draw, play and game-over screens.
- Drives the 6-bit `current_state` bus and the registered 2-bit `map_select` consumed by the map/animation data logic.
- Handshakes with the VGA draw datapath via `draw_start`/`draw_done`.
- Generates the per-frame tick that paces gameplay.

Parameters:
- FRAME_DIV, 833333, clk cycles per frame_tick (50 MHz / 60 Hz); must be ≥2.
- GG_HOLD_FRAMES, 180, frame ticks the game-over screen is held before returning to title; must be ≥1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- button1  input  1  active-high push button, asynchronous to clk.
- button2  input  1  active-high push button, asynchronous to clk.
- game_over  input  1  one-cycle pulse from game logic: player lost.
- draw_done  input  1  one-cycle pulse from draw datapath: current screen finished.
- current_state  output  6  state code (encodings below).
- map_select  output  2  00 MAP1, 01 MAP2, 10 START, 11 GG.
- draw_start  output  1  one-cycle pulse: begin drawing screen given by map_select.
- play_en  output  1  high only in S_PLAY.
- frame_tick  output  1  one-cycle pulse every FRAME_DIV cycles while play_en or in S_GG_HOLD.

Behaviour:
- **Reset** (resetn low, asynchronous): state = S_IDLE (6'd0), map_select = START, draw_start = 0, play_en = 0, frame_tick = 0, frame counter = 0, hold counter = 0, synchronizers = 0. Reset mid-draw aborts the draw; the datapath sees draw_start = 0.
- **Buttons**:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detector (3rd FF).
  - An edge is a one-cycle internal pulse, 3 cycles after the pin rises.
  - Held buttons produce one edge only.
- **State machine** (registered state; outputs registered or decoded from state):
  - S_IDLE 6'd0: next cycle → S_DRAW_TITLE.
  - S_DRAW_TITLE 6'd1: map_select = START. draw_start = 1 in the first cycle in state only. draw_done → S_WAIT_SEL.
  - S_WAIT_SEL 6'd11:
    - map_select stays START.
    - btn1 edge → map_select = MAP1, go to S_DRAW_MAP.
    - btn2 edge alone → map_select = MAP2, go to S_DRAW_MAP.
    - Both edges in the same cycle → MAP1.
  - S_DRAW_MAP 6'd12: draw_start pulse on entry cycle; map_select holds the choice. draw_done → S_PLAY.
  - S_PLAY 6'd13: play_en = 1; map_select holds. game_over → S_DRAW_GG.
  - S_DRAW_GG 6'd14: map_select = GG; draw_start pulse on entry. draw_done → S_GG_HOLD; hold counter cleared.
  - S_GG_HOLD 6'd15: hold counter increments on each frame_tick. The tick on which the counter reaches GG_HOLD_FRAMES → S_DRAW_TITLE.
- **draw_done** is honoured only in DRAW states, and only from the cycle after draw_start onward. draw_done coincident with draw_start is ignored.
- **Ignored events** (not queued):
  - Button edges outside S_WAIT_SEL.
  - game_over outside S_PLAY.
  - draw_done outside DRAW states.
- **Frame counter**:
  - Counts 0..FRAME_DIV-1 while in S_PLAY or S_GG_HOLD, then wraps to 0.
  - frame_tick = 1 in the cycle the counter equals FRAME_DIV-1.
  - Held at 0 in all other states, so the first tick after entry comes FRAME_DIV cycles later.
  - Width = clog2(FRAME_DIV).
- **Same-cycle priority**: game_over arriving on the same cycle as frame_tick → transition wins; tick still pulses that cycle.
- Unused state codes → S_IDLE next cycle.

Test Plan:
- **Reset/title**: FRAME_DIV = 4, GG_HOLD_FRAMES = 3. Release resetn.
  - Cycle 1: current_state 0→1, draw_start = 1 for exactly one cycle, map_select = 10.
  - draw_done 5 cycles later → current_state = 11.
- **Map choice**:
  - In state 11, pulse button2 → 3 cycles later map_select = 01, state 12, draw_start pulse.
  - Repeat with button1 and button2 together → map_select = 00.
- **Play and tick**:
  - draw_done in state 12 → state 13, play_en = 1.
  - frame_tick pulses every 4 cycles, first on the 4th cycle in state.
  - Button presses leave map_select unchanged.
- **Game over**:
  - game_over in state 13 → state 14, map_select = 11, draw_start pulse.
  - draw_done → state 15. After 3 frame ticks (12 cycles) → state 1, map_select = 10.
- **Spurious inputs**:
  - draw_done on the same cycle as draw_start is ignored; state stays 12.
  - game_over in state 11 is ignored.
  - A button held high for 100 cycles gives a single selection.
- **Async reset mid-operation**: assert resetn low mid-cycle in states 12 and 15 → outputs go to reset values immediately without a clock edge; on release the sequence restarts at state 0.
